// File: rtl/exp_adder_pipe.sv
// exp_adder_pipe
// Two-stage pipelined exponent adder for floating-point multiply and divide.
// Stage 1 reduces the three operands (A, B or ~B, and a bias constant that
// already contains the inc/op adjustment) to a carry-save sum/carry pair.
// Stage 2 resolves the pair with a carry-propagate add and derives the
// result exponent and the overflow/underflow flags.
//
// Parameters
//   EXP_W     exponent field width (3..11)
//   TAG_W     width of the opaque sideband tag
// Ports
//   clk       clock, all state updates on its rising edge
//   rst       synchronous active-high reset
//   in_valid  / in_ready   input handshake
//   exp_a, exp_b           biased exponents
//   inc                    normalisation adjust (+1 mul, -1 div)
//   op                     0 = multiply path, 1 = divide path
//   in_tag                 sideband tag travelling with the operation
//   out_valid / out_ready  output handshake
//   exp_out                low EXP_W bits of the wide result
//   ovf, unf               wide result >= 2^EXP_W-1 / wide result <= 0
//   out_tag                tag of the operation currently on exp_out
module exp_adder_pipe #(
    parameter int EXP_W = 5,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             inc,
    input  logic             op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             ovf,
    output logic             unf,
    output logic [TAG_W-1:0] out_tag
);

    // Two guard bits keep every intermediate value exact and signed.
    localparam int W = EXP_W + 2;
    localparam logic signed [W-1:0] BIAS    = W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [W-1:0] OVF_LIM = W'((1 << EXP_W) - 1);

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_sum_q,   s1_sum_d;
    logic [W-1:0]     s1_carry_q, s1_carry_d;
    logic             s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [EXP_W-1:0] s2_exp_q,   s2_exp_d;
    logic             s2_ovf_q,   s2_ovf_d;
    logic             s2_unf_q,   s2_unf_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic                s1_ready, s2_ready;
    logic [W-1:0]        opa, opb, opk, inc_w;
    logic signed [W-1:0] r_wide;

    // Ready chain: a stage can take new data when it is empty or when the
    // stage after it is moving. Reset blocks acceptance in the reset cycle.
    always_comb begin
        s2_ready = ~s2_valid_q | out_ready;
        s1_ready = ~s1_valid_q | s2_ready;
        in_ready = s1_ready & ~rst;
    end

    // Stage 1 operand set. For divide, B is inverted; the +1 that completes
    // the two's-complement negation is applied as carry-in in stage 2, so
    // the constant only carries +/-BIAS and the inc adjustment.
    always_comb begin
        inc_w = {{(W-1){1'b0}}, inc};
        opa   = {2'b00, exp_a};
        opb   = op ? ~{2'b00, exp_b} : {2'b00, exp_b};
        opk   = op ? (BIAS - inc_w) : (inc_w - BIAS);
    end

    // Stage 1 next state: 3:2 carry-save reduction, loaded whenever the
    // stage is free to move, otherwise held.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_carry_d = s1_carry_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            s1_sum_d   = opa ^ opb ^ opk;
            s1_carry_d = {(opa[W-2:0] & opb[W-2:0]) |
                          (opa[W-2:0] & opk[W-2:0]) |
                          (opb[W-2:0] & opk[W-2:0]), 1'b0};
            s1_op_d    = op;
            s1_tag_d   = in_tag;
        end
    end

    // Stage 2 carry-propagate add; the result fits in W bits for every
    // legal operand set, so the carry out of the top bit is discarded.
    always_comb begin
        r_wide = s1_sum_q + s1_carry_q + {{(W-1){1'b0}}, s1_op_q};
    end

    // Stage 2 next state: resolved exponent and flags, held while stalled.
    // exp_out wraps modulo 2^EXP_W; saturation happens downstream.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_exp_d   = s2_exp_q;
        s2_ovf_d   = s2_ovf_q;
        s2_unf_d   = s2_unf_q;
        s2_tag_d   = s2_tag_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            s2_exp_d   = r_wide[EXP_W-1:0];
            s2_ovf_d   = (r_wide >= OVF_LIM);
            s2_unf_d   = r_wide[W-1] | (r_wide == '0);
            s2_tag_d   = s1_tag_q;
        end
    end

    // State registers with synchronous reset that flushes all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
            s1_op_q    <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_exp_q   <= '0;
            s2_ovf_q   <= 1'b0;
            s2_unf_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_carry_q <= s1_carry_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_exp_q   <= s2_exp_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_unf_q   <= s2_unf_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    always_comb begin
        out_valid = s2_valid_q;
        exp_out   = s2_exp_q;
        ovf       = s2_ovf_q;
        unf       = s2_unf_q;
        out_tag   = s2_tag_q;
    end

endmodule

// File: tb/tb_exp_adder_pipe.sv
// tb_exp_adder_pipe
// Directed and model-based checks of exp_adder_pipe at EXP_W=5 and EXP_W=8.
// Both instances share clock and reset; each has its own handshake signals.
module tb_exp_adder_pipe;

    logic clk = 1'b0;
    logic rst;

    logic       in_valid5, in_ready5, inc5, op5, out_valid5, out_ready5;
    logic       ovf5, unf5;
    logic [4:0] a5, b5, exp_out5;
    logic [3:0] in_tag5, out_tag5;

    logic       in_valid8, in_ready8, inc8, op8, out_valid8, out_ready8;
    logic       ovf8, unf8;
    logic [7:0] a8, b8, exp_out8;
    logic [3:0] in_tag8, out_tag8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    exp_adder_pipe #(.EXP_W(5), .TAG_W(4)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5),
        .exp_a(a5), .exp_b(b5), .inc(inc5), .op(op5), .in_tag(in_tag5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .exp_out(exp_out5), .ovf(ovf5), .unf(unf5), .out_tag(out_tag5)
    );

    exp_adder_pipe #(.EXP_W(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .exp_a(a8), .exp_b(b8), .inc(inc8), .op(op8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .exp_out(exp_out8), .ovf(ovf8), .unf(unf8), .out_tag(out_tag8)
    );

    // Reference wide result straight from the defining formulas.
    function automatic int refR(input int e, input int a, input int b,
                                input int inc, input int op);
        int bias;
        bias = (1 << (e - 1)) - 1;
        return op ? (a - b + bias - inc) : (a + b - bias + inc);
    endfunction

    task automatic checkOutput(input string name, input int observed, input int expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input int a, input int b,
                                 input int inc, input int op, input int tag);
        if (sel == 5) begin
            a5 = a[4:0]; b5 = b[4:0]; inc5 = inc[0]; op5 = op[0];
            in_tag5 = tag[3:0]; in_valid5 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; inc8 = inc[0]; op8 = op[0];
            in_tag8 = tag[3:0]; in_valid8 = 1'b1;
        end
    endtask

    // One operation with out_ready high: result must be absent after one
    // edge and present with all fields after exactly two.
    task automatic runVector(input int sel, input int a, input int b, input int inc,
                             input int op, input int tag, input int e_exp,
                             input int e_ovf, input int e_unf, input string name);
        applyStimulus(sel, a, b, inc, op, tag);
        step();
        in_valid5 = 1'b0;
        in_valid8 = 1'b0;
        checkOutput({name, "_lat1"}, sel == 5 ? int'(out_valid5) : int'(out_valid8), 0);
        step();
        if (sel == 5) begin
            checkOutput({name, "_valid"}, int'(out_valid5), 1);
            checkOutput({name, "_exp"}, int'(exp_out5), e_exp);
            checkOutput({name, "_ovf"}, int'(ovf5), e_ovf);
            checkOutput({name, "_unf"}, int'(unf5), e_unf);
            checkOutput({name, "_tag"}, int'(out_tag5), tag);
        end else begin
            checkOutput({name, "_valid"}, int'(out_valid8), 1);
            checkOutput({name, "_exp"}, int'(exp_out8), e_exp);
            checkOutput({name, "_ovf"}, int'(ovf8), e_ovf);
            checkOutput({name, "_unf"}, int'(unf8), e_unf);
            checkOutput({name, "_tag"}, int'(out_tag8), tag);
        end
    endtask

    function automatic int pack5();
        return (int'(out_valid5) << 11) | (int'(exp_out5) << 6) |
               (int'(ovf5) << 5) | (int'(unf5) << 4) | int'(out_tag5);
    endfunction

    // Safety net in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int q[$];
        int occ, sent, rcv, held, held_valid, r, e, a, b, inc, op, exp_packed, sel;
        logic [31:0] pat;

        rst = 1'b1;
        out_ready5 = 1'b1; out_ready8 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; inc8 = 1'b0; op8 = 1'b0; in_tag8 = '0;
        // Operand presented while reset is held must be dropped.
        applyStimulus(5, 15, 15, 0, 0, 9);

        // Reset state
        step();
        step();
        checkOutput("rst_out_valid", int'(out_valid5), 0);
        checkOutput("rst_exp_out", int'(exp_out5), 0);
        checkOutput("rst_ovf", int'(ovf5), 0);
        checkOutput("rst_unf", int'(unf5), 0);
        checkOutput("rst_out_tag", int'(out_tag5), 0);
        checkOutput("rst_in_ready", int'(in_ready5), 0);
        rst = 1'b0;
        in_valid5 = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", int'(in_ready5), 1);
        step();
        step();
        checkOutput("rst_input_dropped", int'(out_valid5), 0);

        // Directed vectors, EXP_W=5
        runVector(5, 15, 15, 0, 0, 3, 15, 0, 0, "mul_15_15");
        runVector(5, 30, 30, 0, 0, 4, 13, 1, 0, "mul_ovf_wrap");
        runVector(5, 1, 1, 0, 0, 5, 19, 0, 1, "mul_unf_wrap");
        runVector(5, 20, 10, 0, 1, 6, 25, 0, 0, "div_inc0");
        runVector(5, 20, 10, 1, 1, 7, 24, 0, 0, "div_inc1");
        runVector(5, 23, 23, 0, 0, 8, 31, 1, 0, "ovf_edge_31");
        runVector(5, 22, 23, 0, 0, 9, 30, 0, 0, "below_ovf_30");
        runVector(5, 8, 7, 0, 0, 10, 0, 0, 1, "unf_edge_0");
        runVector(5, 8, 8, 0, 0, 11, 1, 0, 0, "above_unf_1");
        runVector(5, 0, 31, 1, 1, 12, 15, 0, 1, "div_min");
        runVector(5, 31, 31, 1, 0, 13, 16, 1, 0, "mul_max");

        // Directed vectors, EXP_W=8
        runVector(8, 127, 127, 0, 0, 1, 127, 0, 0, "w8_mul_127");
        runVector(8, 200, 100, 0, 1, 2, 227, 0, 0, "w8_div");
        runVector(8, 255, 255, 1, 0, 3, 128, 1, 0, "w8_mul_max");

        // Back-to-back stream with out_ready held: no bubbles
        for (int k = 0; k < 6; k++) begin
            if (k < 4) applyStimulus(5, k + 4, 15, 0, 0, 8 + k);
            else in_valid5 = 1'b0;
            #1;
            checkOutput("stream_in_ready", int'(in_ready5), 1);
            step();
            checkOutput("stream_out_valid", int'(out_valid5), (k >= 1 && k <= 4) ? 1 : 0);
            if (k >= 1 && k <= 4) checkOutput("stream_tag", int'(out_tag5), 8 + k - 1);
        end

        // Back-pressure: tags 0..7 with a scrambled out_ready pattern
        pat = 32'hB53C_96E1;
        occ = 0; sent = 0; rcv = 0; held = 0; held_valid = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (held_valid != 0) checkOutput("bp_stall_hold", pack5(), held);
            out_ready5 = pat[cyc % 32];
            if (sent < 8) begin
                a = sent * 3 + 5; b = 17 - sent; inc = sent & 1; op = (sent >> 1) & 1;
                applyStimulus(5, a, b, inc, op, sent);
            end else begin
                in_valid5 = 1'b0;
            end
            #2;
            checkOutput("bp_in_ready", int'(in_ready5), (occ < 2 || out_ready5) ? 1 : 0);
            held_valid = (out_valid5 && !out_ready5) ? 1 : 0;
            held = pack5();
            if (out_valid5 && out_ready5) begin
                if (q.size() == 0) begin
                    checkOutput("bp_unexpected_out", 1, 0);
                end else begin
                    exp_packed = q.pop_front();
                    checkOutput("bp_out", pack5(), exp_packed);
                end
                rcv++;
                occ--;
            end
            if (in_valid5 && in_ready5) begin
                r = refR(5, a, b, inc, op);
                q.push_back((1 << 11) | ((r & 31) << 6) | ((r >= 31 ? 1 : 0) << 5) |
                            ((r <= 0 ? 1 : 0) << 4) | sent);
                sent++;
                occ++;
            end
            if (rcv == 8) break;
            @(posedge clk);
            #1;
        end
        checkOutput("bp_received", rcv, 8);
        in_valid5 = 1'b0;
        out_ready5 = 1'b1;
        step();
        step();
        checkOutput("bp_no_dup", int'(out_valid5), 0);

        // Reset with two operations in flight
        out_ready5 = 1'b0;
        applyStimulus(5, 10, 10, 0, 0, 1);
        step();
        applyStimulus(5, 11, 11, 0, 0, 2);
        step();
        in_valid5 = 1'b0;
        checkOutput("full_in_ready", int'(in_ready5), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready5 = 1'b1;
        checkOutput("midrst_out_valid", int'(out_valid5), 0);
        checkOutput("midrst_exp_out", int'(exp_out5), 0);
        step();
        checkOutput("midrst_no_stale1", int'(out_valid5), 0);
        step();
        checkOutput("midrst_no_stale2", int'(out_valid5), 0);
        runVector(5, 16, 16, 1, 0, 14, 18, 0, 0, "after_rst");

        // Random operands against the reference formulas
        for (int i = 0; i < 24; i++) begin
            sel = (i % 2 == 0) ? 5 : 8;
            e = sel;
            a = int'($urandom_range((1 << e) - 1, 0));
            b = int'($urandom_range((1 << e) - 1, 0));
            inc = int'($urandom_range(1, 0));
            op = int'($urandom_range(1, 0));
            r = refR(e, a, b, inc, op);
            runVector(sel, a, b, inc, op, i % 16, r & ((1 << e) - 1),
                      (r >= (1 << e) - 1) ? 1 : 0, (r <= 0) ? 1 : 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exp_adder_pipe.md
EXP_ADDER_PIPE -- requirements
Module: exp_adder_pipe

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width (5 = fp16, 8 = fp32/bf16); legal range 3..11.
REQ-002 Parameter TAG_W, default 4, width of the opaque sideband tag carried alongside each operation.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  operand set present.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port exp_a  input  EXP_W  biased exponent A.
REQ-008 Port exp_b  input  EXP_W  biased exponent B.
REQ-009 Port inc  input  1  normalisation adjust, +1 for mul and -1 for div.
REQ-010 Port op  input  1  0 = multiply exponent path, 1 = divide exponent path.
REQ-011 Port in_tag  input  TAG_W  sideband tag.
REQ-012 Port out_valid  output  1  result present.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port exp_out  output  EXP_W  result exponent, low EXP_W bits of the wide result.
REQ-015 Port ovf  output  1  overflow flag: wide result >= 2^EXP_W - 1.
REQ-016 Port unf  output  1  underflow flag: wide result <= 0.
REQ-017 Port out_tag  output  TAG_W  tag of the operation in exp_out.

Function
REQ-018 BIAS SHALL equal 2^(EXP_W-1) - 1; all internal arithmetic SHALL be signed, EXP_W+2 bits wide, with no intermediate truncation.
REQ-019 op=0: R = exp_a + exp_b - BIAS + inc.
REQ-020 op=1: R = exp_a - exp_b + BIAS - inc.
REQ-021 exp_out = R[EXP_W-1:0]; ovf = (R >= 2^EXP_W - 1); unf = (R <= 0); ovf and unf SHALL never both be 1.
REQ-022 Stage 1 SHALL register the carry-save sum/carry vectors of the three-operand reduction (A, B or ~B, bias constant with the inc/op adjust folded in) plus op and tag.
REQ-023 Stage 2 SHALL register the carry-propagate result R and the derived outputs.
REQ-024 Latency SHALL be exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid when out_ready is held high.
REQ-025 Throughput SHALL be one operation per cycle with no bubbles while out_ready=1.
REQ-026 Ready chain: s2_ready = ~s2_valid | out_ready; s1_ready = ~s1_valid | s2_ready; in_ready = s1_ready.
REQ-027 Occupancy SHALL be at most 2 operations.
REQ-028 A stalled stage SHALL hold its data and valid bit unchanged.
REQ-029 exp_out, ovf, unf and out_tag SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 Output and input handshakes in the same cycle with the pipe full SHALL both complete (simultaneous drain and fill).
REQ-031 Operations SHALL leave the pipe in acceptance order; tags SHALL never be reordered, dropped or duplicated.
REQ-032 Wrap-around: exp_out SHALL be the modulo-2^EXP_W value of R even when ovf or unf is set; saturation is left to the downstream block.

Reset
REQ-033 While rst=1 at a clock edge, s1_valid, s2_valid and out_valid SHALL clear to 0, and exp_out, ovf, unf and out_tag SHALL clear to 0.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear at the output afterwards.
REQ-036 An input presented during the reset cycle SHALL NOT be accepted.

Verification
REQ-037 EXP_W=5, op=0, A=15, B=15, inc=0, out_ready=1 -> two cycles later exp_out=15, ovf=0, unf=0, tag matches.
REQ-038 EXP_W=5, op=0, A=30, B=30, inc=0 -> R=45: exp_out=13, ovf=1. A=1, B=1 -> R=-13: exp_out=19, unf=1.
REQ-039 EXP_W=5, op=1: A=20, B=10, inc=0 -> exp_out=25. Same operands with inc=1 -> exp_out=24. EXP_W=8: A=127, B=127, op=0 -> exp_out=127.
REQ-040 Back-pressure: stream tags 0..7 with out_ready toggled at random -> in_ready drops only with 2 held, outputs stay stable while stalled, tags exit 0..7 in order, none lost.
REQ-041 Reset with 2 operations in flight -> out_valid=0 the following cycle, no stale result emitted, next accepted operation appears after exactly 2 cycles.
REQ-042 Random self-check over EXP_W in {5, 8} -> all fields match the R reference model of REQ-019..REQ-021.
